// File: rtl/serializer_pkg.sv
// serializer_pkg: FSM state type and sizing helpers shared by word_serializer.
// The PARITY state and the parity helper exist only when SERIALIZER_PARITY_EN is defined.
package serializer_pkg;

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
  } state_t;
`endif

  // Bits needed for a counter that can hold the value 'width'.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

`ifdef SERIALIZER_PARITY_EN
  // Even parity: the bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction
`endif

endpackage

// File: rtl/ser_shift_reg.sv
// ser_shift_reg: WIDTH-bit load/shift register; o_head is the bit currently presented.
// Shifting moves the next bit into the head position and fills the far end with zero.
module ser_shift_reg #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  output logic             o_head
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_shifted;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_shifted = {r_q[WIDTH-2:0], 1'b0};
      assign o_head    = r_q[WIDTH-1];
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_q[WIDTH-1:1]};
      assign o_head    = r_q[0];
    end
  endgenerate

  // Word storage: load has priority over shift; everything holds while disabled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= {WIDTH{1'b0}};
    end else if (i_en && i_load) begin
      r_q <= i_d;
    end else if (i_en && i_shift) begin
      r_q <= w_shifted;
    end else begin
      r_q <= r_q;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// word_serializer: captures a WIDTH-bit word and sends it bit by bit over a valid/ready link.
// Define SERIALIZER_PARITY_EN to append one even-parity bit after the data bits.
module word_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             BUSY,
  output logic             SOUT,
  output logic             SVALID,
  input  logic             SREADY,
  output logic             DONE
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 32'sd1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_svalid;
  logic          w_svalid_nxt;
  logic          r_busy;
  logic          w_busy_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          w_sr_load;
  logic          w_sr_shift;
  logic          w_head;
  logic          w_accept;

  assign w_accept = r_svalid & SREADY & ENABLE;

  ser_shift_reg #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .i_clk  (CLK),
    .i_rst_n(RESET),
    .i_en   (ENABLE),
    .i_load (w_sr_load),
    .i_shift(w_sr_shift),
    .i_d    (D),
    .o_head (w_head)
  );

`ifdef SERIALIZER_PARITY_EN
  logic r_parity;

  // Parity of the captured word, presented once all data bits have gone out.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_parity <= 1'b0;
    end else if (ENABLE && w_sr_load) begin
      r_parity <= even_parity(32'(D));
    end else begin
      r_parity <= r_parity;
    end
  end

  assign SOUT = r_svalid & ((r_state == PARITY) ? r_parity : w_head);
`else
  // The register drains to zero, but gating with valid keeps SOUT low between words.
  assign SOUT = r_svalid & w_head;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
    end else if (ENABLE) begin
      r_state <= w_state_nxt;
    end else begin
      r_state <= r_state;
    end
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_svalid_nxt = r_svalid;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_sr_load    = 1'b0;
    w_sr_shift   = 1'b0;
    case (r_state)
      IDLE: begin
        if (LOAD) begin
          w_state_nxt  = SHIFT;
          w_cnt_nxt    = CNT_ZERO;
          w_svalid_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_sr_load    = 1'b1;
        end else begin
          w_svalid_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (w_accept) begin
          w_sr_shift = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = CNT_ZERO;
`ifdef SERIALIZER_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt  = IDLE;
            w_svalid_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          w_sr_shift = 1'b0;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      PARITY: begin
        if (w_accept) begin
          w_state_nxt  = IDLE;
          w_svalid_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
        end else begin
          w_state_nxt = PARITY;
        end
      end
`endif
      default: begin
        w_state_nxt  = IDLE;
        w_cnt_nxt    = CNT_ZERO;
        w_svalid_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
      end
    endcase
  end

  // Counter and registered handshake outputs; all hold while ENABLE is low.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt    <= CNT_ZERO;
      r_svalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (ENABLE) begin
      r_cnt    <= w_cnt_nxt;
      r_svalid <= w_svalid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end else begin
      r_cnt    <= r_cnt;
      r_svalid <= r_svalid;
      r_busy   <= r_busy;
      r_done   <= r_done;
    end
  end

  assign BUSY   = r_busy;
  assign SVALID = r_svalid;
  assign DONE   = r_done;

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: directed checks of word_serializer, one LSB-first and one MSB-first instance.
// Expected sequences include the parity bit when SERIALIZER_PARITY_EN is defined.
module tb_word_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_en, a_load, a_sready;
  logic [3:0] a_d;
  logic       a_busy, a_sout, a_svalid, a_done;
  logic       b_en, b_load, b_sready;
  logic [3:0] b_d;
  logic       b_busy, b_sout, b_svalid, b_done;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
    .CLK(clk), .RESET(rst_n), .ENABLE(a_en), .D(a_d), .LOAD(a_load),
    .BUSY(a_busy), .SOUT(a_sout), .SVALID(a_svalid), .SREADY(a_sready), .DONE(a_done)
  );

  word_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
    .CLK(clk), .RESET(rst_n), .ENABLE(b_en), .D(b_d), .LOAD(b_load),
    .BUSY(b_busy), .SOUT(b_sout), .SVALID(b_svalid), .SREADY(b_sready), .DONE(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_en = 1'b1; a_load = 1'b0; a_sready = 1'b0; a_d = 4'b0000;
    b_en = 1'b1; b_load = 1'b0; b_sready = 1'b0; b_d = 4'b0000;
    #3;
    checks++;
    if ({a_busy, a_svalid, a_sout, a_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_lsb: busy/svalid/sout/done got %b expected 0000", {a_busy, a_svalid, a_sout, a_done});
    end
    checks++;
    if ({b_busy, b_svalid, b_sout, b_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_msb: busy/svalid/sout/done got %b expected 0000", {b_busy, b_svalid, b_sout, b_done});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({a_busy, a_svalid, a_sout, a_done} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_reset: busy/svalid/sout/done got %b expected 0000", {a_busy, a_svalid, a_sout, a_done});
    end
  endtask

  task automatic test_lsb_basic();
    logic [4:0] exp;
    exp = 5'b11011;
    a_d = 4'b1011; a_load = 1'b1; a_sready = 1'b1;
    tick();
    a_load = 1'b0; a_d = 4'b0000;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if ({a_svalid, a_sout, a_busy, a_done} !== {1'b1, exp[i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL lsb_bit%0d: svalid/sout/busy/done got %b expected %b", i,
                 {a_svalid, a_sout, a_busy, a_done}, {1'b1, exp[i], 1'b1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({a_svalid, a_sout, a_busy, a_done} !== 4'b0001) begin
      errors++;
      $display("FAIL lsb_done: svalid/sout/busy/done got %b expected 0001", {a_svalid, a_sout, a_busy, a_done});
    end
    a_sready = 1'b0;
    tick();
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL lsb_done_width: done got %b expected 0", a_done);
    end
  endtask

  task automatic test_msb_toggle();
    logic [4:0] exp;
    int idx;
    exp = 5'b10001;
    idx = 0;
    b_d = 4'b1000; b_load = 1'b1; b_sready = 1'b1;
    tick();
    b_load = 1'b0;
    for (int c = 1; c <= 2 * NB - 1; c++) begin
      b_sready = (c % 2 == 1) ? 1'b1 : 1'b0;
      checks++;
      if ({b_svalid, b_sout, b_done} !== {1'b1, exp[idx], 1'b0}) begin
        errors++;
        $display("FAIL msb_cycle%0d: svalid/sout/done got %b expected %b", c,
                 {b_svalid, b_sout, b_done}, {1'b1, exp[idx], 1'b0});
      end
      tick();
      if (b_sready) idx++;
    end
    b_sready = 1'b0;
    checks++;
    if ({b_svalid, b_busy, b_done} !== 3'b001) begin
      errors++;
      $display("FAIL msb_done: svalid/busy/done got %b expected 001", {b_svalid, b_busy, b_done});
    end
    tick();
    checks++;
    if (b_done !== 1'b0) begin
      errors++;
      $display("FAIL msb_done_width: done got %b expected 0", b_done);
    end
  endtask

  task automatic test_load_while_busy();
    logic [4:0] exp;
    int dones;
    exp = 5'b01111;
    dones = 0;
    a_d = 4'b1111; a_load = 1'b1; a_sready = 1'b1;
    tick();
    a_load = 1'b0;
    for (int c = 1; c <= NB + 3; c++) begin
      a_load = (c == 2 || c == 3) ? 1'b1 : 1'b0;
      a_d    = (c == 2 || c == 3) ? 4'b0110 : 4'b0000;
      if (c <= NB) begin
        checks++;
        if ({a_svalid, a_sout} !== {1'b1, exp[c-1]}) begin
          errors++;
          $display("FAIL busy_load_bit%0d: svalid/sout got %b expected %b", c - 1,
                   {a_svalid, a_sout}, {1'b1, exp[c-1]});
        end
      end
      if (a_done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL busy_load_dones: done pulses got %0d expected 1", dones);
    end
    checks++;
    if ({a_svalid, a_busy} !== 2'b00) begin
      errors++;
      $display("FAIL busy_load_idle: svalid/busy got %b expected 00", {a_svalid, a_busy});
    end
  endtask

  task automatic test_reset_mid_word();
    logic [4:0] exp;
    exp = 5'b10001;
    a_d = 4'b1101; a_load = 1'b1; a_sready = 1'b1;
    tick();
    a_load = 1'b0;
    tick(); tick();
    checks++;
    if ({a_busy, a_svalid, a_sout} !== 3'b111) begin
      errors++;
      $display("FAIL pre_reset_bit2: busy/svalid/sout got %b expected 111", {a_busy, a_svalid, a_sout});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_busy, a_svalid, a_sout, a_done} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset: busy/svalid/sout/done got %b expected 0000", {a_busy, a_svalid, a_sout, a_done});
    end
    tick();
    checks++;
    if (a_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done got %b expected 0", a_done);
    end
    rst_n = 1'b1;
    a_d = 4'b0001; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if ({a_svalid, a_sout, a_done} !== {1'b1, exp[i], 1'b0}) begin
        errors++;
        $display("FAIL post_reset_bit%0d: svalid/sout/done got %b expected %b", i,
                 {a_svalid, a_sout, a_done}, {1'b1, exp[i], 1'b0});
      end
      tick();
    end
    checks++;
    if ({a_svalid, a_done} !== 2'b01) begin
      errors++;
      $display("FAIL post_reset_done: svalid/done got %b expected 01", {a_svalid, a_done});
    end
    a_sready = 1'b0;
    tick();
  endtask

  task automatic test_enable_back_to_back();
    logic [4:0] exp;
    logic [4:0] exp2;
    exp  = 5'b00110;
    exp2 = 5'b01001;
    a_en = 1'b1; a_d = 4'b0110; a_load = 1'b1; a_sready = 1'b1;
    tick();
    a_load = 1'b0;
    checks++;
    if ({a_svalid, a_sout} !== {1'b1, exp[0]}) begin
      errors++;
      $display("FAIL stall_bit0: svalid/sout got %b expected %b", {a_svalid, a_sout}, {1'b1, exp[0]});
    end
    tick();
    a_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({a_svalid, a_sout, a_busy, a_done} !== {1'b1, exp[1], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold%0d: svalid/sout/busy/done got %b expected %b", k,
                 {a_svalid, a_sout, a_busy, a_done}, {1'b1, exp[1], 1'b1, 1'b0});
      end
    end
    a_en = 1'b1;
    for (int i = 1; i < NB; i++) begin
      checks++;
      if ({a_svalid, a_sout, a_done} !== {1'b1, exp[i], 1'b0}) begin
        errors++;
        $display("FAIL resume_bit%0d: svalid/sout/done got %b expected %b", i,
                 {a_svalid, a_sout, a_done}, {1'b1, exp[i], 1'b0});
      end
      tick();
    end
    checks++;
    if ({a_svalid, a_sout, a_busy, a_done} !== 4'b0001) begin
      errors++;
      $display("FAIL stall_done: svalid/sout/busy/done got %b expected 0001", {a_svalid, a_sout, a_busy, a_done});
    end
    a_d = 4'b1001; a_load = 1'b1;
    tick();
    a_load = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if ({a_svalid, a_sout, a_done} !== {1'b1, exp2[i], 1'b0}) begin
        errors++;
        $display("FAIL b2b_bit%0d: svalid/sout/done got %b expected %b", i,
                 {a_svalid, a_sout, a_done}, {1'b1, exp2[i], 1'b0});
      end
      tick();
    end
    checks++;
    if ({a_svalid, a_done} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_done: svalid/done got %b expected 01", {a_svalid, a_done});
    end
    a_sready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lsb_basic();
    test_msb_toggle();
    test_load_while_busy();
    test_reset_mid_word();
    test_enable_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0: 0 shifts bit 0 first, 1 shifts bit WIDTH-1 first.
REQ-003 Port CLK, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port RESET, input, 1: asynchronous, active-low reset; one clock, no other clock domains.
REQ-005 Port ENABLE, input, 1: clock enable; when 0, all state, counters and outputs hold.
REQ-006 Port D, input, WIDTH: parallel word to serialize.
REQ-007 Port LOAD, input, 1: request to capture D.
REQ-008 Port BUSY, output, 1: high from capture until the final bit is accepted.
REQ-009 Port SOUT, output, 1: current serial bit.
REQ-010 Port SVALID, output, 1: SOUT holds a valid bit.
REQ-011 Port SREADY, input, 1: downstream accepts SOUT this cycle.
REQ-012 Port DONE, output, 1: single-cycle pulse after the final bit is accepted.

Function
REQ-013 The FSM SHALL have exactly these states: IDLE, SHIFT and, only when the macro is defined, PARITY.
REQ-014 IDLE -> SHIFT when LOAD=1 and ENABLE=1; D is captured on that edge.
REQ-015 SVALID SHALL rise on the edge after capture, with the first bit on SOUT (one-cycle latency).
REQ-016 A bit is accepted when SVALID, SREADY and ENABLE are all 1; SOUT SHALL stay stable until acceptance.
REQ-017 Each acceptance advances the shift register by one bit and increments a counter sized to hold WIDTH.
REQ-018 Acceptance of the last data bit goes SHIFT -> IDLE, or SHIFT -> PARITY when the macro is defined.
REQ-019 In the cycle after the final acceptance: DONE=1, SVALID=0, BUSY=0 and the FSM is in IDLE.
REQ-020 LOAD while BUSY=1 SHALL be ignored; the captured word is not disturbed.
REQ-021 LOAD during the DONE cycle SHALL be accepted (the FSM is in IDLE).
REQ-022 SREADY held high SHALL yield one bit per cycle with no bubbles.
REQ-023 With SVALID=0, SOUT SHALL be 0.
REQ-024 ENABLE=0 mid-word SHALL freeze everything; the word resumes unaltered when ENABLE returns to 1.

Reset
REQ-025 RESET=0 SHALL immediately force: IDLE, counter 0, shift register 0, SOUT=0, SVALID=0, BUSY=0, DONE=0.
REQ-026 Reset mid-word SHALL abort the transfer with no DONE pulse; the next LOAD starts a fresh word.

Configuration
REQ-027 Macro SERIALIZER_PARITY_EN defined: after the data bits, one even-parity bit (XOR of the captured word) is sent in state PARITY, so WIDTH+1 transfers occur and DONE follows the parity acceptance.
REQ-028 Macro undefined: exactly WIDTH transfers occur, the PARITY state and parity logic are absent, and the port list is unchanged.

Structure
REQ-029 Package serializer_pkg SHALL hold the state typedef, the state encodings (IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10) and the counter-width function.
REQ-030 Sub-module ser_shift_reg SHALL hold the WIDTH-bit register with async active-low reset and load, shift and enable controls; the FSM and counter stay in word_serializer.

Verification
REQ-031 Reset, then LOAD with D=4'b1011, SREADY=1, MSB_FIRST=0 -> SOUT sequence 1,1,0,1 in 4 consecutive cycles starting one cycle after LOAD, then DONE for 1 cycle.
REQ-032 MSB_FIRST=1, D=4'b1000, SREADY toggling 1,0,1,0... -> SOUT 1,0,0,0, each bit held while SREADY=0; DONE after the 4th acceptance.
REQ-033 LOAD with D=4'b0110 while BUSY, mid-word of 4'b1111 -> output stays 1,1,1,1 and only one DONE pulse occurs.
REQ-034 RESET=0 after 2 accepted bits -> outputs go to 0 asynchronously with no DONE; a following LOAD 4'b0001 serializes correctly.
REQ-035 SERIALIZER_PARITY_EN with D=4'b0111 -> SOUT 1,1,1,0 followed by parity bit 1, and DONE after 5 acceptances.
REQ-036 ENABLE=0 for 3 cycles mid-word, then LOAD asserted again in the DONE cycle -> no lost or duplicated bits, and the second word starts one cycle later.
